bt656_trs_decoder: RTL and testbench
====================================

# bt656_trs_decoder

Timing-reference decoder on the 27 MHz BT.656 input bus (camera or colour-bar generator), directly upstream of the capture/YUV conversion stage. Hunts FF 00 00 XY sequences, validates the XY protection bits and tracks the F/V/H flags. Emits a one-cycle-delayed byte stream with an active-video qualifier, line-start and frame-start strobes, word and line counters, and error/lock status for the capture stage.

## Interface
- ACTIVE_WORDS, 1440, expected active bytes per line (720 pixels × 2, U Y V Y order)
- WCNT_W, 11, width of word counter
- LCNT_W, 10, width of line counter
- LOCK_LINES, 4, consecutive good lines required to assert lock

- raw_in_vclk  in  1  byte clock, 27 MHz; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- raw_in_data  in  8  BT.656 byte stream
- out_data  out  8  raw_in_data delayed one cycle
- out_valid  out  1  out_data is an active-video byte
- out_first  out  1  pulse on first active byte of a line
- out_sof  out  1  pulse on first active byte of line 0, field 0
- out_field  out  1  F flag of last valid XY
- out_v_blank  out  1  V flag of last valid XY
- out_h_blank  out  1  H flag of last valid XY
- out_word_cnt  out  WCNT_W  index of the current active byte (0-based)
- out_line_cnt  out  LCNT_W  active line index within field
- err_xy  out  1  pulse: XY byte failed the check
- err_len  out  1  pulse: active line length ≠ ACTIVE_WORDS
- locked  out  1  stream timing stable

## Operation
- TRS detector FSM: S_DATA → (0xFF) S_FF → (0x00) S_Z1 → (0x00) S_Z2 → next byte is XY, then back to S_DATA. Any mismatch returns to S_DATA. A mismatching 0xFF goes to S_FF.
- XY check: bit7 = 1, and P3..P0 = {V^H, F^H, F^V, F^V^H} with F = bit6, V = bit5, H = bit4. On failure: pulse err_xy, clear locked, clear the good-line count, leave flags and counters unchanged, generate no line events.
- Valid XY updates out_field/out_v_blank/out_h_blank.
- SAV (H = 0): arms active. Each following byte is active while word count < ACTIVE_WORDS and byte ≠ 0xFF. Any 0xFF ends the active region, and that byte is not valid. The count clamps at ACTIVE_WORDS, with out_valid low beyond it.
- EAV (H = 1), only if an SAV has been seen since reset:
  - If the count ≠ ACTIVE_WORDS: pulse err_len, clear locked, reset the good-line count.
  - Otherwise: increment the good-line count, saturating at LOCK_LINES. locked sets when it reaches LOCK_LINES.
- Line counter:
  - Cleared at an SAV with V = 0 when the previous valid XY had V = 1.
  - Incremented at each EAV with V = 0.
  - Saturates at all-ones.
- out_valid is not gated by locked. locked is status only.

## Timing
- Reset values: out_data = 0, out_valid = 0, out_first = 0, out_sof = 0, out_field = 0, out_v_blank = 1, out_h_blank = 1, counters = 0, err_xy = 0, err_len = 0, locked = 0, FSM = S_DATA, sav_seen = 0.
- Latency is 1 cycle: out_data/out_valid at cycle n+1 reflect raw_in_data at cycle n.
- Flag outputs change in the cycle after the XY byte is sampled.
- out_first and out_sof coincide with the first out_valid = 1 cycle after SAV. out_word_cnt = 0 in that cycle and increments with each valid byte.
- err_xy and err_len are high for exactly one cycle, in the cycle after the offending XY byte.
- The out_line_cnt update is visible in the cycle after the XY byte.
- TRS bytes (FF 00 00 XY) never have out_valid = 1.
- Reset mid-line aborts immediately: no output pulses, and lock must be re-earned.
- Back-to-back TRS (EAV immediately followed by SAV with no blanking bytes) must decode correctly.

## Test plan
- Field-0 active line: FF 00 00 80, 1440 bytes 0x10/0x80 alternating, FF 00 00 9D → out_valid high for exactly 1440 cycles. out_first and out_word_cnt = 0 on the first; out_word_cnt = 1439 on the last. err_len = 0.
- Frame start: line with FF 00 00 AB … FF 00 00 B6, then an SAV of 0x80 → out_line_cnt = 0 and out_sof pulses once. The next three SAV 0x80 / EAV 0x9D pairs give out_line_cnt 1, 2, 3.
- Lock: 4 good lines → locked rises in the cycle after the 4th EAV. A following line of 1439 bytes → err_len pulse and locked = 0.
- Corrupt XY: FF 00 00 81 → err_xy pulse. Flags and out_line_cnt are unchanged, no out_valid, locked = 0.
- Early EAV: SAV 0x80, 700 data bytes, FF 00 00 9D → out_valid for 700 cycles, FF not flagged valid, err_len pulse. Field-1 SAV 0xC7 → out_field = 1, and the first out_first with line_cnt = 0 gives no out_sof.
- Assert rst_n low at active byte 500 → all outputs take their reset values asynchronously. After release, an EAV without a preceding SAV gives no err_len.

Source files
------------

// File: rtl/bt656_trs_decoder.sv
// Purpose : BT.656 timing-reference decoder; finds FF 00 00 XY, checks XY protection bits,
//           tracks F/V/H and qualifies active-video bytes with word/line counters and lock status.
// Latency : 1 cycle from raw_in_data to out_data/out_valid; flags/pulses update the cycle after XY.
// Backpr. : none; the 27 MHz byte stream cannot be stalled, every input byte is consumed.
//
// Ports:
//   raw_in_vclk  - 27 MHz byte clock, all logic on the rising edge
//   rst_n        - asynchronous active-low reset
//   raw_in_data  - BT.656 byte stream
//   out_data     - raw_in_data delayed one cycle
//   out_valid    - out_data is an active-video byte
//   out_first    - first active byte of a line
//   out_sof      - first active byte of line 0, field 0
//   out_field    - F flag of the last valid XY
//   out_v_blank  - V flag of the last valid XY
//   out_h_blank  - H flag of the last valid XY
//   out_word_cnt - 0-based index of the current active byte
//   out_line_cnt - active line index within the field
//   err_xy       - one-cycle pulse: XY byte failed its protection check
//   err_len      - one-cycle pulse: active line length differs from ACTIVE_WORDS
//   locked       - LOCK_LINES consecutive good lines seen without error
module bt656_trs_decoder #(
    parameter int ACTIVE_WORDS = 1440,
    parameter int WCNT_W       = 11,
    parameter int LCNT_W       = 10,
    parameter int LOCK_LINES   = 4
) (
    input  logic              raw_in_vclk,
    input  logic              rst_n,
    input  logic [7:0]        raw_in_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_sof,
    output logic              out_field,
    output logic              out_v_blank,
    output logic              out_h_blank,
    output logic [WCNT_W-1:0] out_word_cnt,
    output logic [LCNT_W-1:0] out_line_cnt,
    output logic              err_xy,
    output logic              err_len,
    output logic              locked
);

    localparam int                GOOD_W    = $clog2(LOCK_LINES + 1);
    localparam logic [WCNT_W-1:0] ACT_WORDS = WCNT_W'(ACTIVE_WORDS);
    localparam logic [GOOD_W-1:0] LOCK_N    = GOOD_W'(LOCK_LINES);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = {LCNT_W{1'b1}};

    // ------------------------------------------------------------------
    // TRS preamble hunter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FF   = 2'd1,
        S_Z1   = 2'd2,
        S_Z2   = 2'd3
    } state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DATA: begin
                if (raw_in_data == 8'hFF) state_d = S_FF;
            end
            S_FF: begin
                // A run of FFs keeps us waiting for the first zero.
                if (raw_in_data == 8'h00)      state_d = S_Z1;
                else if (raw_in_data != 8'hFF) state_d = S_DATA;
            end
            S_Z1: begin
                if (raw_in_data == 8'h00)      state_d = S_Z2;
                else if (raw_in_data == 8'hFF) state_d = S_FF;
                else                           state_d = S_DATA;
            end
            S_Z2: begin
                // The byte presented now is XY, whatever its value.
                state_d = S_DATA;
            end
            default: state_d = S_DATA;
        endcase
    end

    always_ff @(posedge raw_in_vclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // XY decode
    // ------------------------------------------------------------------
    logic       xy_slot;
    logic       xy_f, xy_v, xy_h;
    logic [3:0] xy_prot;
    logic       xy_ok;
    logic       xy_good, xy_bad;
    logic       is_sav, is_eav;

    assign xy_slot = (state_q == S_Z2);
    assign xy_f    = raw_in_data[6];
    assign xy_v    = raw_in_data[5];
    assign xy_h    = raw_in_data[4];
    assign xy_prot = {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h};
    assign xy_ok   = raw_in_data[7] && (raw_in_data[3:0] == xy_prot);
    assign xy_good = xy_slot && xy_ok;
    assign xy_bad  = xy_slot && !xy_ok;
    assign is_sav  = xy_good && !xy_h;
    assign is_eav  = xy_good && xy_h;

    // ------------------------------------------------------------------
    // Active region, counters, flags and lock tracking
    // ------------------------------------------------------------------
    logic [7:0]        out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_sof_q,   out_sof_d;
    logic              field_q,     field_d;
    logic              vblank_q,    vblank_d;
    logic              hblank_q,    hblank_d;
    logic [WCNT_W-1:0] wcnt_out_q,  wcnt_out_d;
    logic [LCNT_W-1:0] lcnt_q,      lcnt_d;
    logic              err_xy_q,    err_xy_d;
    logic              err_len_q,   err_len_d;
    logic              locked_q,    locked_d;
    logic              sav_seen_q,  sav_seen_d;
    logic              active_q,    active_d;
    logic [WCNT_W-1:0] cnt_q,       cnt_d;
    logic              first_pend_q, first_pend_d;
    logic              sof_pend_q,  sof_pend_d;
    logic [GOOD_W-1:0] good_q,      good_d;

    // An armed line passes bytes until it has ACTIVE_WORDS of them; an FF
    // (start of the next TRS) is never video and closes the region.
    logic byte_act;
    assign byte_act = active_q && (cnt_q < ACT_WORDS) && (raw_in_data != 8'hFF);

    always_comb begin
        out_data_d   = raw_in_data;
        out_valid_d  = byte_act;
        out_first_d  = byte_act && first_pend_q;
        out_sof_d    = byte_act && first_pend_q && sof_pend_q;
        field_d      = field_q;
        vblank_d     = vblank_q;
        hblank_d     = hblank_q;
        wcnt_out_d   = wcnt_out_q;
        lcnt_d       = lcnt_q;
        err_xy_d     = xy_bad;
        err_len_d    = 1'b0;
        locked_d     = locked_q;
        sav_seen_d   = sav_seen_q;
        active_d     = active_q;
        cnt_d        = cnt_q;
        first_pend_d = first_pend_q;
        sof_pend_d   = sof_pend_q;
        good_d       = good_q;

        // Active byte bookkeeping; cnt_q saturates at ACTIVE_WORDS because
        // byte_act drops once it gets there.
        if (byte_act) begin
            wcnt_out_d   = cnt_q;
            cnt_d        = cnt_q + 1'b1;
            first_pend_d = 1'b0;
        end
        if (raw_in_data == 8'hFF) begin
            active_d = 1'b0;
        end

        if (xy_good) begin
            field_d  = xy_f;
            vblank_d = xy_v;
            hblank_d = xy_h;
        end

        if (xy_bad) begin
            locked_d = 1'b0;
            good_d   = '0;
        end

        if (is_sav) begin
            // Leaving vertical blanking starts a new field's line numbering.
            if (!xy_v && vblank_q) begin
                lcnt_d = '0;
            end
            active_d     = 1'b1;
            cnt_d        = '0;
            first_pend_d = 1'b1;
            sof_pend_d   = !xy_f && (lcnt_d == '0);
            sav_seen_d   = 1'b1;
        end

        if (is_eav) begin
            active_d     = 1'b0;
            first_pend_d = 1'b0;
            if (!xy_v && (lcnt_q != LCNT_MAX)) begin
                lcnt_d = lcnt_q + 1'b1;
            end
            // Without a prior SAV there is no measured line to judge.
            if (sav_seen_q) begin
                if (cnt_q != ACT_WORDS) begin
                    err_len_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                end else begin
                    if (good_q != LOCK_N) begin
                        good_d = good_q + 1'b1;
                    end
                    if (good_d == LOCK_N) begin
                        locked_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge raw_in_vclk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            field_q      <= 1'b0;
            vblank_q     <= 1'b1;
            hblank_q     <= 1'b1;
            wcnt_out_q   <= '0;
            lcnt_q       <= '0;
            err_xy_q     <= 1'b0;
            err_len_q    <= 1'b0;
            locked_q     <= 1'b0;
            sav_seen_q   <= 1'b0;
            active_q     <= 1'b0;
            cnt_q        <= '0;
            first_pend_q <= 1'b0;
            sof_pend_q   <= 1'b0;
            good_q       <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_sof_q    <= out_sof_d;
            field_q      <= field_d;
            vblank_q     <= vblank_d;
            hblank_q     <= hblank_d;
            wcnt_out_q   <= wcnt_out_d;
            lcnt_q       <= lcnt_d;
            err_xy_q     <= err_xy_d;
            err_len_q    <= err_len_d;
            locked_q     <= locked_d;
            sav_seen_q   <= sav_seen_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
            first_pend_q <= first_pend_d;
            sof_pend_q   <= sof_pend_d;
            good_q       <= good_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_sof      = out_sof_q;
    assign out_field    = field_q;
    assign out_v_blank  = vblank_q;
    assign out_h_blank  = hblank_q;
    assign out_word_cnt = wcnt_out_q;
    assign out_line_cnt = lcnt_q;
    assign err_xy       = err_xy_q;
    assign err_len      = err_len_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_bt656_trs_decoder.sv
// Purpose : directed bench for bt656_trs_decoder; expected output per driven byte goes to a queue.
// Latency : checker pops one entry per cycle, 1 ns after the edge that samples the byte.
// Backpr. : none; the stimulus drives one byte every cycle while a step is running.
module tb_bt656_trs_decoder;

    localparam int AW = 1440;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic [7:0]  out_data;
    logic        out_valid, out_first, out_sof;
    logic        out_field, out_v_blank, out_h_blank;
    logic [10:0] out_word_cnt;
    logic [9:0]  out_line_cnt;
    logic        err_xy, err_len, locked;

    bt656_trs_decoder #(
        .ACTIVE_WORDS(AW), .WCNT_W(11), .LCNT_W(10), .LOCK_LINES(4)
    ) dut (
        .raw_in_vclk (clk),
        .rst_n       (rst_n),
        .raw_in_data (din),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_first   (out_first),
        .out_sof     (out_sof),
        .out_field   (out_field),
        .out_v_blank (out_v_blank),
        .out_h_blank (out_h_blank),
        .out_word_cnt(out_word_cnt),
        .out_line_cnt(out_line_cnt),
        .err_xy      (err_xy),
        .err_len     (err_len),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        vld, first, sof, exy, elen;
        logic [10:0] wcnt;
        logic        chk_stat;
        logic        field, vb, hb;
        logic [9:0]  lcnt;
        logic        locked;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t quiet(input logic [7:0] b);
        exp_t e;
        e.data = b;   e.vld = 1'b0; e.first = 1'b0; e.sof = 1'b0;
        e.exy = 1'b0; e.elen = 1'b0; e.wcnt = '0;   e.chk_stat = 1'b0;
        e.field = 1'b0; e.vb = 1'b0; e.hb = 1'b0;  e.lcnt = '0; e.locked = 1'b0;
        return e;
    endfunction

    task automatic drive_e(input exp_t e, input logic [7:0] b);
        @(negedge clk);
        din = b;
        sb_q.push_back(e);
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) drive_e(quiet(8'h10), 8'h10);
    endtask

    task automatic trs(input logic [7:0] xy, input logic exy, input logic elen,
                       input logic fld, input logic vb, input logic hb,
                       input logic [9:0] lc, input logic lk);
        exp_t e;
        drive_e(quiet(8'hFF), 8'hFF);
        drive_e(quiet(8'h00), 8'h00);
        drive_e(quiet(8'h00), 8'h00);
        e = quiet(xy);
        e.exy = exy; e.elen = elen; e.chk_stat = 1'b1;
        e.field = fld; e.vb = vb; e.hb = hb; e.lcnt = lc; e.locked = lk;
        drive_e(e, xy);
    endtask

    task automatic active(input int n, input logic sof,
                          input logic fld, input logic vb, input logic hb,
                          input logic [9:0] lc, input logic lk);
        exp_t       e;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = i[0] ? 8'h80 : 8'h10;
            e = quiet(b);
            e.vld = 1'b1; e.first = (i == 0); e.sof = sof && (i == 0);
            e.wcnt = 11'(i);
            e.chk_stat = (i == 0) || (i == n - 1);
            e.field = fld; e.vb = vb; e.hb = hb; e.lcnt = lc; e.locked = lk;
            drive_e(e, b);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_data"},   32'(out_data),     32'h00);
        chk({tag, "_valid"},  32'(out_valid),    32'h0);
        chk({tag, "_first"},  32'(out_first),    32'h0);
        chk({tag, "_sof"},    32'(out_sof),      32'h0);
        chk({tag, "_field"},  32'(out_field),    32'h0);
        chk({tag, "_vblank"}, 32'(out_v_blank),  32'h1);
        chk({tag, "_hblank"}, 32'(out_h_blank),  32'h1);
        chk({tag, "_wcnt"},   32'(out_word_cnt), 32'h0);
        chk({tag, "_lcnt"},   32'(out_line_cnt), 32'h0);
        chk({tag, "_errxy"},  32'(err_xy),       32'h0);
        chk({tag, "_errlen"}, 32'(err_len),      32'h0);
        chk({tag, "_locked"}, 32'(locked),       32'h0);
    endtask

    // Output checker: one queued expectation per sampled input byte.
    exp_t m;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            chk("out_data",  32'(out_data),  32'(m.data));
            chk("out_valid", 32'(out_valid), 32'(m.vld));
            chk("out_first", 32'(out_first), 32'(m.first));
            chk("out_sof",   32'(out_sof),   32'(m.sof));
            chk("err_xy",    32'(err_xy),    32'(m.exy));
            chk("err_len",   32'(err_len),   32'(m.elen));
            if (m.vld) chk("word_cnt", 32'(out_word_cnt), 32'(m.wcnt));
            if (m.chk_stat) begin
                chk("field",    32'(out_field),    32'(m.field));
                chk("v_blank",  32'(out_v_blank),  32'(m.vb));
                chk("h_blank",  32'(out_h_blank),  32'(m.hb));
                chk("line_cnt", 32'(out_line_cnt), 32'(m.lcnt));
                chk("locked",   32'(locked),       32'(m.locked));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        din   = 8'h00;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Field-0 active line straight after reset (line 0, field 0 -> SOF).
        filler(4);
        trs(8'h80, 0, 0, 0, 0, 0, 10'd0, 0);
        active(AW, 1, 0, 0, 0, 10'd0, 0);
        trs(8'h9D, 0, 0, 0, 0, 1, 10'd1, 0);

        // Back-to-back EAV->SAV into a vertical-blanking line, then frame start.
        trs(8'hAB, 0, 0, 0, 1, 0, 10'd1, 0);
        active(AW, 0, 0, 1, 0, 10'd1, 0);
        trs(8'hB6, 0, 0, 0, 1, 1, 10'd1, 0);
        trs(8'h80, 0, 0, 0, 0, 0, 10'd0, 0);
        active(AW, 1, 0, 0, 0, 10'd0, 0);
        trs(8'h9D, 0, 0, 0, 0, 1, 10'd1, 0);

        // Lines 1..3; the fourth consecutive good EAV (line 1) sets lock.
        for (int k = 1; k <= 3; k++) begin
            filler(8);
            trs(8'h80, 0, 0, 0, 0, 0, 10'(k), k > 1);
            active(AW, 0, 0, 0, 0, 10'(k), k > 1);
            trs(8'h9D, 0, 0, 0, 0, 1, 10'(k + 1), 1);
        end

        // One byte short: length error drops lock.
        trs(8'h80, 0, 0, 0, 0, 0, 10'd4, 1);
        active(AW - 1, 0, 0, 0, 0, 10'd4, 1);
        trs(8'h9D, 0, 1, 0, 0, 1, 10'd5, 0);

        // Corrupt XY: error pulse, flags/line count held, nothing armed.
        filler(4);
        trs(8'h81, 1, 0, 0, 0, 1, 10'd5, 0);
        filler(4);

        // Early EAV after 700 bytes.
        trs(8'h80, 0, 0, 0, 0, 0, 10'd5, 0);
        active(700, 0, 0, 0, 0, 10'd5, 0);
        trs(8'h9D, 0, 1, 0, 0, 1, 10'd6, 0);

        // Field 1: blanking SAV/EAV pair (empty line), then line 0 without SOF.
        trs(8'hEC, 0, 0, 1, 1, 0, 10'd6, 0);
        trs(8'hF1, 0, 1, 1, 1, 1, 10'd6, 0);
        trs(8'hC7, 0, 0, 1, 0, 0, 10'd0, 0);
        active(AW, 0, 1, 0, 0, 10'd0, 0);
        trs(8'hDA, 0, 0, 1, 0, 1, 10'd1, 0);

        // Asynchronous reset while active byte 500 is on the bus.
        trs(8'hC7, 0, 0, 1, 0, 0, 10'd1, 0);
        active(500, 0, 1, 0, 0, 10'd1, 0);
        @(negedge clk);
        din = 8'h10;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // EAV with no SAV since reset: no length error.
        trs(8'hB6, 0, 0, 0, 1, 1, 10'd0, 0);
        trs(8'h80, 0, 0, 0, 0, 0, 10'd0, 0);
        active(4, 1, 0, 0, 0, 10'd0, 0);
        trs(8'h9D, 0, 1, 0, 0, 1, 10'd1, 0);

        repeat (3) @(posedge clk);
        #2 chk("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
